// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a word-addressed data memory.
//   Turns byte/half/word loads and stores into word transactions.
//   Sub-word stores run as read-modify-write; loads are sign/zero extended.
//   Stalls the pipeline until each access completes.
//   Every access ends with a one-cycle RspValid pulse, flagged AddrErr or BusErr on failure.
// Ports:
//   clk, rst_n                   clock (posedge) and asynchronous active-low reset
//   ReqValid/ReqWrite/ReqSize/   pipeline request, held stable while Stall=1
//   ReqSigned/ReqAddr/ReqWData
//   Stall                        combinational pipeline freeze
//   RspValid/RspData/AddrErr/    registered completion pulse with extended load data and error flags
//   BusErr
//   MemAddr/MemWData/MemRead/    word-aligned memory strobe interface; MemReady completes a strobe
//   MemWrite/MemRData/MemReady
module mem_access_unit #(
    parameter int ADDR_LIMIT_BITS = 12,
    parameter int MAX_WAIT        = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        Stall,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        AddrErr,
    output logic        BusErr,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemRData,
    input  logic        MemReady
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RD, RMW_RD, WR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          addr_err_q, addr_err_d;
    logic          bus_err_q, bus_err_d;
    logic [WW-1:0] wait_q, wait_d;

    logic          accept, req_bad, timeout;
    logic [4:0]    shamt;
    logic [31:0]   lane_mask, lane, load_ext, merged;

    always_comb begin
        // The RspValid cycle consumes the request still held on ReqValid.
        accept    = state_q == IDLE && ReqValid && !rsp_valid_q;
        req_bad   = ReqSize == 2'b11 || (ReqSize == 2'b01 && ReqAddr[0]) ||
                    (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00) || |(ReqAddr >> ADDR_LIMIT_BITS);
        // Word accesses are aligned, so the half-lane shift is zero for them too.
        shamt     = size_q == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
        lane_mask = size_q == 2'b00 ? 32'h0000_00FF : size_q == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        lane      = (MemRData >> shamt) & lane_mask;
        load_ext  = signed_q && size_q == 2'b00 ? {{24{lane[7]}}, lane[7:0]} :
                    signed_q && size_q == 2'b01 ? {{16{lane[15]}}, lane[15:0]} : lane;
        merged    = (MemRData & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
        timeout   = !MemReady && wait_q == WW'(MAX_WAIT - 1);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = ReqAddr;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    wdata_d  = ReqWData;
                    wait_d   = '0;
                    if (req_bad) begin
                        rsp_valid_d = 1'b1;
                        addr_err_d  = 1'b1;
                    end else begin
                        state_d = !ReqWrite ? RD : ReqSize == 2'b10 ? WR : RMW_RD;
                    end
                end
            end
            RD: begin
                if (MemReady) begin
                    rsp_data_d  = load_ext;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            RMW_RD: begin
                if (MemReady) begin
                    wdata_d = merged;
                    wait_d  = '0;
                    state_d = WR;
                end
            end
            WR: begin
                if (MemReady) begin
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
        // Wait states count in every memory state; a timeout abandons the access without writing.
        if (state_q != IDLE && !MemReady) begin
            wait_d = wait_q + 1'b1;
            if (timeout) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                bus_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        Stall    = state_q != IDLE || (ReqValid && !rsp_valid_q);
        RspValid = rsp_valid_q;
        RspData  = rsp_data_q;
        AddrErr  = addr_err_q;
        BusErr   = bus_err_q;
        MemAddr  = {addr_q[31:2], 2'b00};
        MemWData = wdata_q;
        MemRead  = state_q == RD || state_q == RMW_RD;
        MemWrite = state_q == WR;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized transaction-level check of mem_access_unit against a behavioural model.
module tb_mem_access_unit;
    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ReqValid = 1'b0, ReqWrite = 1'b0, ReqSigned = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic [31:0] ReqAddr = '0, ReqWData = '0;
    logic        Stall, RspValid, AddrErr, BusErr, MemRead, MemWrite, MemReady;
    logic [31:0] RspData, MemAddr, MemWData, MemRData;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_LIMIT_BITS(12), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .Stall(Stall), .RspValid(RspValid), .RspData(RspData), .AddrErr(AddrErr), .BusErr(BusErr),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemRData(MemRData), .MemReady(MemReady)
    );

    // Environment memory: answers after d_rd / d_wr not-ready cycles per strobe phase.
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic        load_mem = 1'b0;
    int          d_rd = 0, d_wr = 0, cnt = 0, wr_commits = 0;
    int          checks = 0, failures = 0;

    assign MemRData = mem[MemAddr[11:2]];
    assign MemReady = (MemRead && cnt == d_rd) || (MemWrite && cnt == d_wr);

    always @(posedge clk) begin
        cnt <= ((MemRead || MemWrite) && !MemReady) ? cnt + 1 : 0;
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
        end else if (MemWrite && MemReady) begin
            mem[MemAddr[11:2]] <= MemWData;
            wr_commits <= wr_commits + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
        return sz != 2'b11 && (a % (32'd1 << sz)) == 0 && a < 32'd4096;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input bit sg, input logic [31:0] a);
        int unsigned nb, off;
        logic [31:0] v;
        nb  = 1 << sz;
        off = a % 4;
        if (nb == 4) return word;
        v = (word >> (8 * off)) % (32'd1 << (8 * nb));
        if (sg && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        for (int i = 0; i < (1 << sz); i++) b[a % 4 + i] = wd[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Starts #1 after a posedge, returns #1 after a posedge with ReqValid low.
    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                          input logic [31:0] wd, input int drd, input int dwr,
                          output logic [31:0] got_data, output bit got_aerr, output bit got_berr);
        bit ok, berr;
        int idx, rd_len, wr_len, rd_s, rd_e, wr_s, wr_e, lat, wc0;
        logic [31:0] old_word, exp_word, exp_rsp;
        ok       = legal(sz, a);
        idx      = a[11:2];
        old_word = ref_mem[idx];
        rd_len   = drd < MAXW ? drd + 1 : MAXW;
        wr_len   = dwr < MAXW ? dwr + 1 : MAXW;
        rd_s = 1; rd_e = 0; wr_s = 1; wr_e = 0; berr = 0; exp_rsp = '0;
        exp_word = ok && w ? model_store(old_word, sz, a, wd) : old_word;
        if (!ok) begin
            lat = 1;
        end else if (!w) begin
            rd_e = rd_len; lat = 1 + rd_len; berr = drd >= MAXW;
            if (!berr) exp_rsp = model_load(old_word, sz, sg, a);
        end else if (sz == 2'b10) begin
            wr_e = wr_len; lat = 1 + wr_len; berr = dwr >= MAXW;
        end else begin
            rd_e = rd_len;
            if (drd >= MAXW) begin
                lat = 1 + rd_len; berr = 1;
            end else begin
                wr_s = rd_len + 1; wr_e = rd_len + wr_len; lat = 1 + rd_len + wr_len; berr = dwr >= MAXW;
            end
        end
        d_rd = drd; d_wr = dwr; wc0 = wr_commits;
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
        got_data = '0; got_aerr = 0; got_berr = 0;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk("stall", Stall, c < lat);
            chk("mem_read", MemRead, c >= rd_s && c <= rd_e);
            chk("mem_write", MemWrite, c >= wr_s && c <= wr_e);
            if (MemRead || MemWrite) chk("mem_addr", MemAddr, {a[31:2], 2'b00});
            if (MemWrite) chk("mem_wdata", MemWData, exp_word);
            chk("rsp_valid", RspValid, c == lat);
            if (c == lat) begin
                got_data = RspData; got_aerr = AddrErr; got_berr = BusErr;
                chk("rsp_data", RspData, exp_rsp);
                chk("addr_err", AddrErr, !ok);
                chk("bus_err", BusErr, berr);
            end
            @(posedge clk); #1;
        end
        ReqValid = 1'b0;
        for (int k = 0; k < 64 && (MemRead || MemWrite || RspValid); k++) begin
            @(posedge clk); #1;
        end
        chk("drain", {MemRead, MemWrite, RspValid}, 0);
        chk("mem_word", mem[idx], (ok && w && !berr) ? exp_word : old_word);
        chk("write_count", wr_commits - wc0, ok && w && !berr);
        ref_mem[idx] = (ok && w && !berr) ? exp_word : old_word;
    endtask

    logic [31:0] d, a, wd, keep;
    bit          ae, be, w, sg;
    logic [1:0]  sz;
    int          drd, dwr;

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        return r == 0 ? MAXW - 1 : r == 1 ? MAXW : r == 2 ? 20 : $urandom_range(0, 3);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        load_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;
        chk("rst_rsp_valid", RspValid, 0);
        chk("rst_addr_err", AddrErr, 0);
        chk("rst_bus_err", BusErr, 0);
        chk("rst_mem_read", MemRead, 0);
        chk("rst_mem_write", MemWrite, 0);
        chk("rst_rsp_data", RspData, 0);
        chk("rst_mem_addr", MemAddr, 0);
        chk("rst_mem_wdata", MemWData, 0);
        chk("rst_stall", Stall, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with literal expectations.
        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, d, ae, be);
        do_req(0, 2'b10, 0, 32'h10, 0, 0, 0, d, ae, be);
        chk("lw_deadbeef", d, 32'hDEADBEEF);
        do_req(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, d, ae, be);
        do_req(1, 2'b00, 0, 32'h13, 32'h80, 0, 0, d, ae, be);
        chk("sb_merge", mem[4], 32'h80223344);
        do_req(0, 2'b00, 1, 32'h13, 0, 0, 0, d, ae, be);
        chk("lb_signed", d, 32'hFFFFFF80);
        do_req(0, 2'b00, 0, 32'h13, 0, 1, 0, d, ae, be);
        chk("lbu", d, 32'h00000080);
        do_req(0, 2'b01, 1, 32'h12, 0, 0, 0, d, ae, be);
        chk("lh_signed", d, 32'hFFFF8022);
        do_req(0, 2'b01, 1, 32'h11, 0, 0, 0, d, ae, be);
        chk("lh_misaligned", ae, 1);
        do_req(0, 2'b10, 0, 32'h20, 0, 99, 0, d, ae, be);
        chk("lw_timeout", be, 1);
        do_req(0, 2'b10, 0, 32'h1000, 0, 0, 0, d, ae, be);
        chk("lw_out_of_range", ae, 1);
        do_req(0, 2'b11, 0, 32'h40, 0, 0, 0, d, ae, be);
        chk("illegal_size", ae, 1);
        do_req(1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 2, 1, d, ae, be);
        do_req(0, 2'b10, 0, 32'h30, 0, 0, 0, d, ae, be);
        chk("b2b_lw", d, 32'hCAFEF00D);

        // Reset while the read-modify-write sits in its write phase.
        keep = mem[16];
        d_rd = 0; d_wr = 99;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqSigned = 1'b0;
        ReqAddr = 32'h41; ReqWData = 32'h5A;
        for (int k = 0; k < 10 && !MemWrite; k++) @(negedge clk);
        chk("rmw_reaches_wr", MemWrite, 1);
        rst_n = 1'b0;
        ReqValid = 1'b0;
        #1;
        chk("async_rst_write", MemWrite, 0);
        chk("async_rst_read", MemRead, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_stall", Stall, 0);
        @(negedge clk);
        chk("post_rst_rsp", RspValid, 0);
        chk("post_rst_mem", mem[16], keep);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            w  = $urandom_range(0, 1);
            sg = $urandom_range(0, 1);
            sz = $urandom_range(0, 9) < 9 ? 2'($urandom_range(0, 2)) : 2'b11;
            a  = $urandom_range(0, 511);
            if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            wd  = $urandom;
            drd = pick_delay();
            dwr = pick_delay();
            do_req(w, sz, sg, a, wd, drd, dwr, d, ae, be);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
